// File: rtl/fsm_input_arbiter.sv
// Shares the A/B inputs of a 2-bit control FSM between N_REQ requesters, one grant at a time.
// Build option ARB_FIXED_PRIORITY_EN: lowest-index winner instead of round-robin.
module fsm_input_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 15,
    parameter int TW      = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req,
    input  logic [N_REQ-1:0]     req_a,
    input  logic [N_REQ-1:0]     req_b,
    input  logic [2*N_REQ-1:0]   req_target,
    input  logic [1:0]           state_in,
    output logic                 fsm_a,
    output logic                 fsm_b,
    output logic                 fsm_reset,
    output logic [N_REQ-1:0]     grant,
    output logic [N_REQ-1:0]     done,
    output logic                 timeout_err,
    output logic                 busy
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {IDLE, DRIVE, RELEASE} ctrl_t;

    ctrl_t            ctrl;
    logic [IW-1:0]    win_idx;
    logic [IW-1:0]    pick_idx;
    logic [TW-1:0]    timer;
    logic [1:0]       win_target;
    logic [N_REQ-1:0] win_onehot;

`ifdef ARB_FIXED_PRIORITY_EN
    function automatic logic [IW-1:0] fixed_pick(input logic [N_REQ-1:0] r);
        logic [IW-1:0] sel;
        sel = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (r[i]) sel = IW'(i);
        end
        return sel;
    endfunction

    assign pick_idx = fixed_pick(req);
`else
    logic [IW-1:0] rr_ptr;

    // Scan upward from the pointer, wrapping past N_REQ-1 back to 0.
    function automatic logic [IW-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                              input logic [IW-1:0]    ptr);
        logic [IW-1:0] sel;
        logic [IW-1:0] jj;
        logic          found;
        int            j;
        sel   = '0;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            j = int'(ptr) + i;
            if (j >= N_REQ) j = j - N_REQ;
            jj = IW'(j);
            if (!found && r[jj]) begin
                sel   = jj;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
        return (int'(i) == N_REQ - 1) ? '0 : i + 1'b1;
    endfunction

    assign pick_idx = rr_pick(req, rr_ptr);
`endif

    assign win_target = req_target[{win_idx, 1'b0} +: 2];
    assign win_onehot = N_REQ'(1) << win_idx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl        <= IDLE;
`ifndef ARB_FIXED_PRIORITY_EN
            rr_ptr      <= '0;
`endif
            win_idx     <= '0;
            timer       <= '0;
            fsm_a       <= 1'b0;
            fsm_b       <= 1'b0;
            fsm_reset   <= 1'b0;
            grant       <= '0;
            done        <= '0;
            timeout_err <= 1'b0;
            busy        <= 1'b0;
        end else begin
            done        <= '0;
            timeout_err <= 1'b0;
            fsm_reset   <= 1'b0;
            case (ctrl)
                IDLE: begin
                    fsm_a <= 1'b0;
                    fsm_b <= 1'b0;
                    grant <= '0;
                    busy  <= 1'b0;
                    if (|req) begin
                        ctrl    <= DRIVE;
                        win_idx <= pick_idx;
                        grant   <= N_REQ'(1) << pick_idx;
                        timer   <= '0;
                        busy    <= 1'b1;
                    end
                end
                DRIVE: begin
                    fsm_a <= req_a[win_idx];
                    fsm_b <= req_b[win_idx];
                    // Target match outranks a dropped request, which outranks timeout.
                    if (state_in == win_target) begin
                        done  <= win_onehot;
                        ctrl  <= RELEASE;
                        grant <= '0;
                        fsm_a <= 1'b0;
                        fsm_b <= 1'b0;
                    end else if (!req[win_idx]) begin
                        ctrl  <= RELEASE;
                        grant <= '0;
                        fsm_a <= 1'b0;
                        fsm_b <= 1'b0;
                    end else if (timer == TW'(TIMEOUT - 1)) begin
                        timeout_err <= 1'b1;
                        fsm_reset   <= 1'b1;
                        ctrl        <= RELEASE;
                        grant       <= '0;
                        fsm_a       <= 1'b0;
                        fsm_b       <= 1'b0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                RELEASE: begin
                    ctrl  <= IDLE;
                    busy  <= 1'b0;
                    grant <= '0;
                    fsm_a <= 1'b0;
                    fsm_b <= 1'b0;
`ifndef ARB_FIXED_PRIORITY_EN
                    rr_ptr <= next_idx(win_idx);
`endif
                end
                default: begin
                    ctrl  <= IDLE;
                    busy  <= 1'b0;
                    grant <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fsm_input_arbiter.sv
// Directed-vector bench for fsm_input_arbiter; expectations are hand-computed per cycle.
// Honours ARB_FIXED_PRIORITY_EN to pick the matching set of expected grants.
module tb_fsm_input_arbiter;

    localparam int N = 4;
`ifdef ARB_FIXED_PRIORITY_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req, req_a, req_b;
    logic [2*N-1:0] req_target;
    logic [1:0]     state_in;
    logic           fsm_a, fsm_b, fsm_reset, timeout_err, busy;
    logic [N-1:0]   grant, done;

    int n_vec = 0;
    int n_err = 0;

    fsm_input_arbiter #(.N_REQ(N), .TIMEOUT(15), .TW(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_target  (req_target),
        .state_in    (state_in),
        .fsm_a       (fsm_a),
        .fsm_b       (fsm_b),
        .fsm_reset   (fsm_reset),
        .grant       (grant),
        .done        (done),
        .timeout_err (timeout_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [N-1:0] exp_g;

    initial begin
        reset      = 1'b1;
        req        = 4'b1111;
        req_a      = '0;
        req_b      = '0;
        req_target = '0;
        state_in   = 2'b00;

        // Reset held for 3 cycles with all requests high
        for (int c = 0; c < 3; c++) begin
            step();
            check_val("rst_grant", 32'(grant), 32'h0);
            check_val("rst_busy", 32'(busy), 32'h0);
            check_val("rst_done", 32'(done), 32'h0);
            check_val("rst_ab", 32'({fsm_a, fsm_b}), 32'h0);
            check_val("rst_terr", 32'({timeout_err, fsm_reset}), 32'h0);
        end
        reset = 1'b0;

        // All requesters held, every target already matched: 3 cycles per grant
        for (int k = 0; k < 5; k++) begin
            exp_g = FIXED ? 4'b0001 : 4'(1 << (k % 4));
            step();
            check_val("rr_grant", 32'(grant), 32'(exp_g));
            check_val("rr_busy", 32'(busy), 32'h1);
            step();
            check_val("rr_done", 32'(done), 32'(exp_g));
            check_val("rr_rel_grant", 32'(grant), 32'h0);
            step();
            check_val("rr_idle", 32'({grant, done, busy}), 32'h0);
        end
        req = '0;

        // Single requester drives A=1 toward S1
        req        = 4'b0001;
        req_a      = 4'b0001;
        req_target = 8'b00_00_00_01;
        step();
        check_val("t2_grant", 32'(grant), 32'h1);
        check_val("t2_a_lat", 32'(fsm_a), 32'h0);
        step();
        check_val("t2_fsm_a", 32'(fsm_a), 32'h1);
        check_val("t2_nodone", 32'(done), 32'h0);
        state_in = 2'b01;
        step();
        check_val("t2_done", 32'(done), 32'h1);
        check_val("t2_rel", 32'({grant, fsm_a, busy}), 32'h1);
        req      = '0;
        req_a    = '0;
        state_in = 2'b00;
        step();
        check_val("t2_idle1", 32'({grant, done, busy}), 32'h0);
        step();
        check_val("t2_idle2", 32'({grant, busy}), 32'h0);

        // Unreachable target: timeout after 15 DRIVE cycles
        req        = 4'b0100;
        req_target = 8'b00_11_00_00;
        step();
        check_val("t4_grant", 32'(grant), 32'h4);
        for (int i = 1; i < 15; i++) begin
            step();
            if (timeout_err !== 1'b0 || grant !== 4'b0100)
                check_val("t4_early", 32'({timeout_err, grant}), 32'h4);
        end
        check_val("t4_hold", 32'({timeout_err, fsm_reset, grant}), 32'h4);
        step();
        check_val("t4_terr", 32'(timeout_err), 32'h1);
        check_val("t4_frst", 32'(fsm_reset), 32'h1);
        check_val("t4_drop", 32'({grant, done}), 32'h0);
        req = 4'b1101;
        step();
        check_val("t4_pulse_end", 32'({timeout_err, fsm_reset}), 32'h0);
        exp_g = FIXED ? 4'b0001 : 4'b1000;
        step();
        check_val("t4_next", 32'(grant), 32'(exp_g));
        step();
        check_val("t4_next_done", 32'(done), 32'(exp_g));
        req = '0;
        step(2);

        // Granted requester withdraws on DRIVE cycle 3
        req        = 4'b0010;
        req_target = 8'b00_00_11_00;
        step();
        check_val("t5_grant", 32'(grant), 32'h2);
        step(2);
        check_val("t5_still", 32'(grant), 32'h2);
        req = '0;
        step();
        check_val("t5_rel", 32'({grant, done, timeout_err, fsm_reset}), 32'h0);
        check_val("t5_busy", 32'(busy), 32'h1);
        step();
        check_val("t5_idle", 32'(busy), 32'h0);

        // Target match on the timeout cycle: done wins
        req        = 4'b0001;
        req_target = 8'b00_00_00_10;
        step();
        check_val("t6_grant", 32'(grant), 32'h1);
        step(14);
        check_val("t6_pre", 32'({done, timeout_err}), 32'h0);
        state_in = 2'b10;
        step();
        check_val("t6_done", 32'(done), 32'h1);
        check_val("t6_noerr", 32'({timeout_err, fsm_reset}), 32'h0);
        req      = '0;
        state_in = 2'b00;
        step(2);

        // Asynchronous reset mid-DRIVE drops grant before the next edge
        req        = 4'b0001;
        req_target = 8'b00_00_00_11;
        step();
        check_val("t6b_grant", 32'(grant), 32'h1);
        step();
        reset = 1'b1;
        #1;
        check_val("t6b_async", 32'({grant, busy}), 32'h0);
        check_val("t6b_flags", 32'({done, timeout_err, fsm_reset}), 32'h0);
        step();
        reset = 1'b0;
        req   = '0;
        step();
        check_val("t6b_after", 32'({grant, busy}), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fsm_input_arbiter.md
Name: fsm_input_arbiter

Overview:
- Shares the A/B stimulus inputs of the 2-bit control state machine (S0=00, S1=01, S2=10, S3=11) between N_REQ requesters.
- Grants one requester at a time and forwards that requester's A/B onto the FSM inputs.
- Watches the FSM's state output and releases the grant when the requester's target state is reached, the requester drops its request, or a timeout expires.
- Sits between the requester agents and the FSM; on timeout it forces the FSM back to S0 by pulsing the FSM reset.

Parameters:
N_REQ, 4, number of requesters (2..8)
TIMEOUT, 15, max DRIVE cycles before abort (1..2^TW-1)
TW, 4, timeout counter width

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high
req  input  N_REQ  per-requester request level
req_a  input  N_REQ  per-requester A value
req_b  input  N_REQ  per-requester B value
req_target  input  2*N_REQ  per-requester target state; requester i uses bits [2i+1:2i]
state_in  input  2  FSM state output
fsm_a  output  1  A to FSM
fsm_b  output  1  B to FSM
fsm_reset  output  1  reset to FSM, 1-cycle pulse
grant  output  N_REQ  one-hot grant
done  output  N_REQ  1-cycle pulse: target reached for granted requester
timeout_err  output  1  1-cycle pulse: DRIVE aborted by timeout
busy  output  1  high when not in IDLE

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high, named reset.
- All outputs are registered.
- While reset is high: ctrl state=IDLE, rr pointer=0, timer=0, and all outputs (fsm_a, fsm_b, fsm_reset, grant, done, timeout_err, busy) are 0.
- Asserting reset mid-DRIVE drops the grant immediately (asynchronously); no done or timeout_err is produced.
- Controller states: IDLE, DRIVE, RELEASE.
- IDLE:
  - fsm_a=fsm_b=0, grant=0.
  - If any req bit is high at edge k, then from edge k: state=DRIVE, grant=onehot(winner), timer=0, busy=1.
  - Winner: first set req bit scanning upward from rr pointer, wrapping at N_REQ-1 -> 0.
- DRIVE, evaluated each edge using the winner w:
  - fsm_a<=req_a[w], fsm_b<=req_b[w], so there is one cycle of input latency.
  - Check (a), highest priority: state_in==req_target[w] -> done[w]=1 for one cycle, go to RELEASE.
  - Check (b): req[w]==0 -> go to RELEASE; no done, no error.
  - Check (c): timer==TIMEOUT-1 -> timeout_err=1 and fsm_reset=1, each for one cycle; go to RELEASE.
  - Otherwise: timer+1.
  - Simultaneous events resolve in priority (a) > (b) > (c). Example: target match on the timeout cycle gives done and no error.
  - The target check also applies on the first DRIVE cycle. If the FSM already sits in the target state, done fires after 1 cycle.
- RELEASE, exactly one cycle:
  - grant=0, fsm_a=fsm_b=0, busy=1.
  - rr pointer <= (w+1) mod N_REQ, then go to IDLE.
- Minimum turnaround between grants is 2 cycles (RELEASE then IDLE). A requester that holds req high re-arbitrates normally after that.
- Changes to req bits of non-granted requesters during DRIVE have no effect.
- The timer saturates and cannot wrap, because exit at TIMEOUT-1 is guaranteed.
- grant is always one-hot or zero. done is at most one-hot and only ever on the granted index.

Optional Feature:
- Macro: ARB_FIXED_PRIORITY_EN.
- Defined: the winner is the lowest-index set req bit; the rr pointer is not used and is not updated.
- Undefined (default): round-robin as above.

Test Plan:
1. Reset held 3 cycles with req=4'b1111 -> all outputs 0; after release, grant=0001 on the first edge.
2. req[0]=1, req_a[0]=1, target=01, FSM starts at S0 -> fsm_a=1 next cycle; FSM reaches S1; done[0] pulses once; RELEASE then IDLE; grant=0000 for 2 cycles.
3. req=4'b1111 held, targets reachable -> grant order 0001, 0010, 0100, 1000, 0001. With ARB_FIXED_PRIORITY_EN defined -> always 0001.
4. req[2]=1, target=11, which is unreachable from S0 with A/B only, TIMEOUT=15 -> after 15 DRIVE cycles timeout_err=1 and fsm_reset=1 for 1 cycle; FSM returns to S0; next grant goes to index 3 first.
5. Granted requester drops req mid-DRIVE (cycle 3) -> RELEASE next edge; no done, no timeout_err.
6. Target match coincides with timer==TIMEOUT-1 -> done pulses; timeout_err and fsm_reset stay 0. Separately, async reset asserted mid-DRIVE -> grant=0 before the next clock edge.
